// File: rtl/pc_unit_if.sv
// rtl/pc_unit_if.sv - request/response bundle between the fetch control and pc_unit
interface pc_unit_if #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
);
  logic                           PCWrite;
  logic                           br_taken;
  logic [WIDTH-1:0]               br_target;
  logic                           call;
  logic                           ret;
  logic                           exc;
  logic                           eret;
  logic [WIDTH-1:0]               addr;
  logic [WIDTH-1:0]               epc;
  logic [$clog2(RAS_DEPTH):0]     ras_count;
  logic                           ras_empty;
  logic                           ras_full;

  modport master (
    output PCWrite, br_taken, br_target, call, ret, exc, eret,
    input  addr, epc, ras_count, ras_empty, ras_full
  );

  modport slave (
    input  PCWrite, br_taken, br_target, call, ret, exc, eret,
    output addr, epc, ras_count, ras_empty, ras_full
  );
endinterface

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with exception vectoring and a circular return-address stack
module pc_unit #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = 32'h0000_3000,
  parameter logic [WIDTH-1:0] EXC_VEC   = 32'h0000_4180,
  parameter int               STEP      = 4,
  parameter int               RAS_DEPTH = 4
) (
  input logic     clk,
  input logic     rst,
  pc_unit_if.slave bus
);
  localparam int              PW       = $clog2(RAS_DEPTH);
  localparam int              CW       = PW + 1;
  localparam logic [CW-1:0]   FULL_CNT = CW'(RAS_DEPTH);
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] epc_q;
  logic [PW-1:0]    top_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] ras_top;
  logic             ras_nonempty;
  logic             advance;
  logic             do_pop;
  logic             do_push;

  // top_q points at the next free slot, so the newest entry sits one below it
  always_comb begin
    seq_pc       = pc_q + STEP_W;
    ras_top      = ras_mem[top_q - 1'b1];
    ras_nonempty = (cnt_q != '0);
    advance      = bus.PCWrite && !bus.exc;
    do_pop       = advance && !bus.eret && bus.ret && ras_nonempty;
    do_push      = advance && !bus.eret && !bus.ret && bus.br_taken && bus.call;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q  <= RESET_VEC;
      epc_q <= '0;
      top_q <= '0;
      cnt_q <= '0;
    end else if (bus.exc) begin
      pc_q  <= EXC_VEC;
      epc_q <= pc_q;
    end else if (bus.PCWrite) begin
      if (bus.eret)
        pc_q <= epc_q;
      else if (bus.ret)
        pc_q <= ras_nonempty ? ras_top : bus.br_target;
      else if (bus.br_taken)
        pc_q <= bus.br_target;
      else
        pc_q <= seq_pc;

      // a push into a full stack overwrites the oldest slot; the count saturates
      if (do_pop) begin
        top_q <= top_q - 1'b1;
        cnt_q <= cnt_q - 1'b1;
      end else if (do_push) begin
        top_q <= top_q + 1'b1;
        if (cnt_q != FULL_CNT)
          cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && do_push)
      ras_mem[top_q] <= seq_pc;
  end

  assign bus.addr      = pc_q;
  assign bus.epc       = epc_q;
  assign bus.ras_count = cnt_q;
  assign bus.ras_empty = (cnt_q == '0);
  assign bus.ras_full  = (cnt_q == FULL_CNT);
endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - scoreboard bench for pc_unit with directed vectors
module tb_pc_unit;
  localparam logic [5:0] P = 6'b100000;  // PCWrite
  localparam logic [5:0] X = 6'b010000;  // exc
  localparam logic [5:0] E = 6'b001000;  // eret
  localparam logic [5:0] R = 6'b000100;  // ret
  localparam logic [5:0] B = 6'b000010;  // br_taken
  localparam logic [5:0] C = 6'b000001;  // call
  localparam logic [5:0] N = 6'b000000;

  typedef struct {
    logic [31:0] a;
    logic [31:0] e;
    logic [2:0]  c;
  } exp_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   entry;
  exp_t exp_q[$];
  event chk_ev;

  pc_unit_if #(.WIDTH(32), .RAS_DEPTH(4)) bus ();

  pc_unit #(
    .WIDTH(32), .RESET_VEC(32'h0000_3000), .EXC_VEC(32'h0000_4180),
    .STEP(4), .RAS_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s #%0d actual=%h required=%h", nm, idx, act, req);
    end
  endtask

  // monitor: compares the oldest expectation whenever outputs are sampled
  initial begin
    forever begin
      @(negedge clk or chk_ev);
      if (exp_q.size() != 0) begin
        exp_t x;
        x = exp_q.pop_front();
        check("addr", entry, bus.addr, x.a);
        check("epc", entry, bus.epc, x.e);
        check("ras_count", entry, 32'(bus.ras_count), 32'(x.c));
        check("ras_empty", entry, 32'(bus.ras_empty), 32'(x.c == 3'd0));
        check("ras_full", entry, 32'(bus.ras_full), 32'(x.c == 3'd4));
        entry++;
      end
    end
  end

  task automatic drive(input logic [5:0] req, input logic [31:0] tgt);
    bus.PCWrite   = req[5];
    bus.exc       = req[4];
    bus.eret      = req[3];
    bus.ret       = req[2];
    bus.br_taken  = req[1];
    bus.call      = req[0];
    bus.br_target = tgt;
  endtask

  task automatic cyc(input logic [5:0] req, input logic [31:0] tgt,
                     input logic [31:0] ea, input logic [31:0] ee, input logic [2:0] ec);
    @(negedge clk);
    drive(req, tgt);
    @(posedge clk);
    #1;
    exp_q.push_back('{a: ea, e: ee, c: ec});
  endtask

  // reset pulse between edges, with a redirect, push and exception pending
  task automatic reset_pulse();
    @(negedge clk);
    #2 drive(P | X | B | C, 32'h0000_5555);
    #1 rst = 1'b0;
    #1 exp_q.push_back('{a: 32'h0000_3000, e: 32'h0, c: 3'd0});
    -> chk_ev;
    #2 drive(N, 32'h0);
    #1 rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    errors = 0;
    checks = 0;
    entry  = 0;
    rst    = 1'b0;
    drive(N, 32'h0);
    exp_q.push_back('{a: 32'h0000_3000, e: 32'h0, c: 3'd0});
    @(negedge clk);
    #1 rst = 1'b1;

    cyc(P,         32'h0,         32'h0000_3004, 32'h0, 3'd0);
    cyc(P,         32'h0,         32'h0000_3008, 32'h0, 3'd0);
    cyc(P,         32'h0,         32'h0000_300C, 32'h0, 3'd0);
    cyc(N,         32'h0,         32'h0000_300C, 32'h0, 3'd0);
    cyc(N,         32'h0,         32'h0000_300C, 32'h0, 3'd0);
    cyc(P,         32'h0,         32'h0000_3010, 32'h0, 3'd0);
    cyc(P | B | C, 32'h0000_3400, 32'h0000_3400, 32'h0, 3'd1);
    cyc(P | R,     32'h0,         32'h0000_3014, 32'h0, 3'd0);
    // five nested calls into a four-deep stack
    cyc(P | B,     32'h0000_3000, 32'h0000_3000, 32'h0, 3'd0);
    cyc(P | B | C, 32'h0000_3100, 32'h0000_3100, 32'h0, 3'd1);
    cyc(P | B | C, 32'h0000_3200, 32'h0000_3200, 32'h0, 3'd2);
    cyc(P | B | C, 32'h0000_3300, 32'h0000_3300, 32'h0, 3'd3);
    cyc(P | B | C, 32'h0000_3400, 32'h0000_3400, 32'h0, 3'd4);
    cyc(P | B | C, 32'h0000_3500, 32'h0000_3500, 32'h0, 3'd4);
    cyc(P | R,     32'h0,         32'h0000_3404, 32'h0, 3'd3);
    cyc(P | R,     32'h0,         32'h0000_3304, 32'h0, 3'd2);
    cyc(P | R,     32'h0,         32'h0000_3204, 32'h0, 3'd1);
    cyc(P | R,     32'h0,         32'h0000_3104, 32'h0, 3'd0);
    cyc(P | R,     32'h0000_3800, 32'h0000_3800, 32'h0, 3'd0);
    // exception entry while stalled, then return
    cyc(P | B,     32'h0000_3020, 32'h0000_3020, 32'h0,          3'd0);
    cyc(X,         32'h0,         32'h0000_4180, 32'h0000_3020, 3'd0);
    cyc(P,         32'h0,         32'h0000_4184, 32'h0000_3020, 3'd0);
    cyc(P | E,     32'h0,         32'h0000_3020, 32'h0000_3020, 3'd0);
    cyc(P | B | C, 32'h0000_3600, 32'h0000_3600, 32'h0000_3020, 3'd1);
    cyc(P | X | E | R | B, 32'h0000_3900, 32'h0000_4180, 32'h0000_3600, 3'd1);
    cyc(P | C,     32'h0,         32'h0000_4184, 32'h0000_3600, 3'd1);
    cyc(P | C | R | B, 32'h0000_3A00, 32'h0000_3024, 32'h0000_3600, 3'd0);
    cyc(B | C,     32'h0000_3B00, 32'h0000_3024, 32'h0000_3600, 3'd0);
    cyc(E | R,     32'h0000_3B00, 32'h0000_3024, 32'h0000_3600, 3'd0);
    // wrap at the top of the address space, including the pushed return address
    cyc(P | B,     32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_3600, 3'd0);
    cyc(P,         32'h0,         32'h0000_0000, 32'h0000_3600, 3'd0);
    cyc(P | B,     32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_3600, 3'd0);
    cyc(P | B | C, 32'h0000_0100, 32'h0000_0100, 32'h0000_3600, 3'd1);
    cyc(P | R,     32'h0,         32'h0000_0000, 32'h0000_3600, 3'd0);
    cyc(P | B | C, 32'h0000_0200, 32'h0000_0200, 32'h0000_3600, 3'd1);
    reset_pulse();
    cyc(P,         32'h0,         32'h0000_3004, 32'h0, 3'd0);
    cyc(P | R,     32'h0000_3700, 32'h0000_3700, 32'h0, 3'd0);

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning address width in bits.
REQ-002 SHALL have parameter RESET_VEC, default 32'h0000_3000, meaning PC value after reset.
REQ-003 SHALL have parameter EXC_VEC, default 32'h0000_4180, meaning exception handler entry address.
REQ-004 SHALL have parameter STEP, default 4, meaning sequential increment.
REQ-005 SHALL have parameter RAS_DEPTH, default 4, meaning return-address-stack entries (power of two, at least 2).
REQ-006 SHALL have one clock and an asynchronous, active-low reset.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
REQ-007 SHALL have these ports:
- PCWrite  in  1  update enable; 0 = stall.
- br_taken  in  1  redirect to br_target.
- br_target  in  WIDTH  branch or jump target.
- call  in  1  with br_taken, push return address.
- ret  in  1  pop RAS and redirect to top.
- exc  in  1  exception request.
- eret  in  1  return from exception.
- addr  out  WIDTH  current PC.
- epc  out  WIDTH  saved exception PC.
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_empty  out  1  ras_count==0.
- ras_full  out  1  ras_count==RAS_DEPTH.

Function
REQ-008 SHALL update addr only on a rising clk edge; next value SHALL be selected by fixed priority exc > eret > ret > br_taken > sequential.
REQ-009 exc=1 SHALL load addr<=EXC_VEC and epc<=addr regardless of PCWrite, and SHALL leave the RAS unchanged.
REQ-010 With PCWrite=0 and exc=0, addr, epc and the RAS SHALL hold; all other requests SHALL be ignored.
REQ-011 With PCWrite=1, eret=1 SHALL load addr<=epc.
REQ-012 With PCWrite=1 and ret=1 and RAS non-empty, addr SHALL load the top entry and ras_count SHALL decrement by 1.
REQ-013 With PCWrite=1 and ret=1 and RAS empty, addr SHALL load br_target and ras_count SHALL stay 0 (underflow fallback).
REQ-014 With PCWrite=1 and br_taken=1, addr SHALL load br_target.
REQ-015 With PCWrite=1, br_taken=1 and call=1, the unit SHALL also push addr+STEP (mod 2^WIDTH).
REQ-016 call without br_taken SHALL be ignored.
REQ-017 call and ret both asserted SHALL perform ret only, with no push.
REQ-018 Otherwise, with PCWrite=1, addr SHALL load addr+STEP, wrapping modulo 2^WIDTH.
REQ-019 Push when full SHALL overwrite the oldest entry, with the RAS kept as a circular buffer, and ras_count SHALL stay RAS_DEPTH.
REQ-020 A later pop SHALL return entries newest-first; after RAS_DEPTH pops the stack SHALL be empty.
REQ-021 The RAS SHALL be implemented as a top pointer that wraps modulo RAS_DEPTH, plus a saturating count.
REQ-022 All arithmetic SHALL be WIDTH bits with the carry discarded.
REQ-023 All outputs SHALL be registered or decoded from registers only, with no combinational path from any input to any output.

Reset
REQ-024 rst=0 SHALL immediately, without a clock edge, force addr=RESET_VEC, epc=0, ras_count=0, ras_empty=1, ras_full=0, and RAS pointer=0.
REQ-025 Reset asserted mid-operation SHALL discard any pending redirect, push or exception.
REQ-026 Operation SHALL resume on the first rising edge after rst returns to 1.
REQ-027 RAS entry contents need not be reset and SHALL NOT be observable while ras_count=0.

Verification
REQ-028 Reset then 3 cycles with PCWrite=1 and no requests SHALL give addr 0x3000 -> 0x3004 -> 0x3008 -> 0x300C; holding PCWrite=0 for 2 cycles SHALL keep 0x300C.
REQ-029 At addr=0x3010, br_taken=1, call=1, br_target=0x3400 SHALL give addr=0x3400 and ras_count=1; next ret=1 SHALL give addr=0x3014 and ras_count=0.
REQ-030 Five calls from 0x3000, 0x3100, 0x3200, 0x3300, 0x3400 with RAS_DEPTH=4 SHALL give ras_full=1; four rets SHALL return 0x3404, 0x3304, 0x3204, 0x3104, then ras_empty=1.
REQ-031 A fifth ret with br_target=0x3800 SHALL give addr=0x3800 and ras_count=0.
REQ-032 At addr=0x3020, exc=1 with PCWrite=0 SHALL give addr=0x4180 and epc=0x3020; a later eret=1 with PCWrite=1 SHALL give addr=0x3020.
REQ-033 At addr=0xFFFF_FFFC (WIDTH=32), a sequential step SHALL give addr=0x0000_0000.
REQ-034 rst pulsed low between clock edges SHALL set addr=0x3000 and ras_count=0 before the next edge.
REQ-035 exc, eret, ret and br_taken asserted together SHALL give addr=0x4180 and leave ras_count unchanged.
